// File: rtl/toy_prog_loader_if.sv
// Byte-stream receive link plus instruction-memory write port of the Toy CPU boot loader.
// master: the loader side; slave: the stream source / memory side.
interface toy_prog_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/toy_prog_loader.sv
// Toy CPU boot loader: header count, then high/low byte pairs written to imem from address 0.
// Optional trailing XOR checksum byte when TOY_LOADER_CHECKSUM_EN is defined.
module toy_prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  toy_prog_loader_if.master   bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [15:0] MAX_COUNT = 16'(1 << ADDR_W);

  typedef enum logic [3:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
`ifdef TOY_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERROR
  } state_t;

  state_t            state;
  logic              rx_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        hi_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  wcnt_q;
`ifdef TOY_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              xfer;
  logic [15:0]       hdr_count;
  logic [CNT_W-1:0]  wcnt_next;

  assign xfer      = bus.rx_valid & rx_ready_q;
  assign hdr_count = {hi_q, bus.rx_data};
  assign wcnt_next = wcnt_q + CNT_W'(1);

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hi_q       <= '0;
      count_q    <= '0;
      wcnt_q     <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef TOY_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
`ifdef TOY_LOADER_CHECKSUM_EN
      // Folds in every accepted byte; the checksum byte itself is compared before it would matter.
      if (xfer) csum_q <= csum_q ^ bus.rx_data;
`endif
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= HDR_HI;
            rx_ready_q <= 1'b1;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            addr_q     <= '0;
            wcnt_q     <= '0;
`ifdef TOY_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end

        HDR_HI: begin
          if (xfer) begin
            hi_q  <= bus.rx_data;
            state <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (xfer) begin
            if (hdr_count == '0 || hdr_count > MAX_COUNT) begin
              state      <= ERROR;
              rx_ready_q <= 1'b0;
              cpu_reset  <= 1'b1;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else begin
              count_q <= hdr_count[CNT_W-1:0];
              state   <= DAT_HI;
            end
          end
        end

        DAT_HI: begin
          if (xfer) begin
            hi_q  <= bus.rx_data;
            state <= DAT_LO;
          end
        end

        DAT_LO: begin
          if (xfer) begin
            wdata_q    <= DATA_W'({hi_q, bus.rx_data});
            we_q       <= 1'b1;
            rx_ready_q <= 1'b0;
            state      <= WRITE;
          end
        end

        WRITE: begin
          we_q   <= 1'b0;
          wcnt_q <= wcnt_next;
          // Address is held on the final word so a full-size load never wraps to 0.
          if (wcnt_next == count_q) begin
`ifdef TOY_LOADER_CHECKSUM_EN
            state      <= CHK;
            rx_ready_q <= 1'b1;
`else
            state      <= DONE;
            cpu_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            addr_q     <= addr_q + ADDR_W'(1);
            rx_ready_q <= 1'b1;
            state      <= DAT_HI;
          end
        end

`ifdef TOY_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            rx_ready_q <= 1'b0;
            busy       <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state     <= DONE;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= ERROR;
              cpu_reset <= 1'b1;
              error     <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state      <= IDLE;
          rx_ready_q <= 1'b0;
          we_q       <= 1'b0;
          busy       <= 1'b0;
          cpu_reset  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_toy_prog_loader.sv
// Scoreboard bench for toy_prog_loader: expected imem writes queued by stimulus, checked by a monitor.
module tb_toy_prog_loader;
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, error;

  int n_cmp = 0;
  int n_err = 0;

  logic [27:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  run_xor;
  logic [27:0] mon_e;

  toy_prog_loader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  toy_prog_loader #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.master),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every imem write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("imem_write", 32'({bus.imem_addr, bus.imem_wdata}), 32'(mon_e));
      end
    end
  end

  task automatic expect_write(input int a, input logic [15:0] d);
    exp_q.push_back({12'(a), d});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit took;
    took = 1'b0;
    bus.rx_data = b;
    for (int t = 0; t < 64 && !took; t++) begin
      bus.rx_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      took = bus.rx_valid && bus.rx_ready;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    if (took) run_xor = run_xor ^ b;
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_accept_timeout: byte 0x%0h not accepted in 64 cycles, expected acceptance", b);
    end
  endtask

  task automatic send_all(input bit rnd);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), rnd);
  endtask

  task automatic start_load();
    start = 1'b1;
    run_xor = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("start_error_clr", 32'(error), 32'd0);
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Called one cycle after the last data byte is accepted (loader is in its write cycle).
  task automatic finish_ok(input string tag);
    logic [7:0] c;
    check({tag, "_last_we"}, 32'(bus.imem_we), 32'd1);
    check({tag, "_hold_cpu"}, 32'(cpu_reset), 32'd1);
`ifdef TOY_LOADER_CHECKSUM_EN
    c = run_xor;
    send_byte(c, 1'b0);
`else
    c = 8'h00;
    @(posedge clk);
    #1;
`endif
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    reset = 1'b1;
    start = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    run_xor = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // count=2: two words at 0 and 1
    expect_write(0, 16'h1234);
    expect_write(1, 16'hABCD);
    start_load();
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_all(1'b0);
    finish_ok("cnt2");

    // Reset while waiting for a low data byte, then reload from address 0
    start_load();
    tx_q = '{8'h00, 8'h02, 8'h12};
    send_all(1'b0);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    expect_write(0, 16'hBEEF);
    start_load();
    tx_q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    send_all(1'b0);
    finish_ok("reload");

    // count=0 aborts without any write
    start_load();
    tx_q = '{8'h00, 8'h00};
    send_all(1'b0);
    check("cnt0_error", 32'(error), 32'd1);
    check("cnt0_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cnt0_busy", 32'(busy), 32'd0);
    check("cnt0_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("cnt0_error_held", 32'(error), 32'd1);

    // start clears the error; count=3 with randomly gapped rx_valid
    expect_write(0, 16'h0102);
    expect_write(1, 16'hF00D);
    expect_write(2, 16'h7E81);
    start_load();
    tx_q = '{8'h00, 8'h03, 8'h01, 8'h02, 8'hF0, 8'h0D, 8'h7E, 8'h81};
    send_all(1'b1);
    finish_ok("cnt3_gaps");

    // Full 4096-word load ends at 0xFFF without wrapping
    start_load();
    tx_q = '{8'h10, 8'h00};
    for (int i = 0; i < 4096; i++) begin
      w = 16'(i * 7) ^ 16'hC35A;
      expect_write(i, w);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
    end
    send_all(1'b0);
    check("full_last_addr", 32'(bus.imem_addr), 32'h0000_0FFF);
    finish_ok("full");
    check("full_addr_hold", 32'(bus.imem_addr), 32'h0000_0FFF);

    // count=0x1001 is out of range
    start_load();
    tx_q = '{8'h10, 8'h01};
    send_all(1'b0);
    check("cnt1001_error", 32'(error), 32'd1);
    check("cnt1001_cpu_reset", 32'(cpu_reset), 32'd1);

`ifdef TOY_LOADER_CHECKSUM_EN
    // Checksum 0x00^0x01^0x12^0x34 = 0x27
    expect_write(0, 16'h1234);
    start_load();
    tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_all(1'b0);
    send_byte(8'h27, 1'b0);
    check("chk_good_done", 32'(done), 32'd1);
    check("chk_good_cpu_reset", 32'(cpu_reset), 32'd0);

    expect_write(0, 16'h1234);
    start_load();
    tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_all(1'b0);
    send_byte(8'h26, 1'b0);
    check("chk_bad_error", 32'(error), 32'd1);
    check("chk_bad_done", 32'(done), 32'd0);
    check("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
